// File: rtl/axi4_lite_pkg.sv
// Shared constants and types for the AXI4-Lite memory scheduler: response codes, FSM state
// encoding and arbiter grant identifiers.
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRdMem  = 2'd1,
      StRdResp = 2'd2,
      StWrResp = 2'd3
   } state_e;

   localparam logic GRANT_RD = 1'b0;
   localparam logic GRANT_WR = 1'b1;

   function automatic logic [1:0] resp_of(input logic in_range);
      return in_range ? RESP_OKAY : RESP_SLVERR;
   endfunction

endpackage

// File: rtl/axi4_lite_rr_arb.sv
// Two-requester read/write arbiter. Round-robin on last_grant by default; defining
// AXI_LITE_RD_PRIO_EN selects fixed read priority with no grant history.
module axi4_lite_rr_arb
   import axi4_lite_pkg::*;
(
   input  logic ACLK,
   input  logic ARESETN,
   input  logic req_rd_i,
   input  logic req_wr_i,
   output logic gnt_rd_o,
   output logic gnt_wr_o
);

`ifdef AXI_LITE_RD_PRIO_EN
   logic unused_clk_rst;
   assign unused_clk_rst = ACLK ^ ARESETN;

   assign gnt_rd_o = req_rd_i;
   assign gnt_wr_o = req_wr_i & ~req_rd_i;
`else
   logic last_grant_q;

   // On a tie the side that did not win last time is served.
   assign gnt_rd_o = req_rd_i & (~req_wr_i | (last_grant_q == GRANT_WR));
   assign gnt_wr_o = req_wr_i & (~req_rd_i | (last_grant_q == GRANT_RD));

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         last_grant_q <= GRANT_WR;
      end else if (gnt_rd_o) begin
         last_grant_q <= GRANT_RD;
      end else if (gnt_wr_o) begin
         last_grant_q <= GRANT_WR;
      end
   end
`endif

endmodule

// File: rtl/axi4_lite_mem_sched.sv
// AXI4-Lite slave scheduling one word-addressed synchronous memory between read and write
// channels, one transaction at a time. Optional macro AXI_LITE_RD_PRIO_EN: fixed read priority.
module axi4_lite_mem_sched
   import axi4_lite_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DATA_DEPTH    = 32,
   localparam int unsigned IDX_W        = $clog2(DATA_DEPTH),
   localparam int unsigned STRB_W       = DATA_WIDTH / 8
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic [ADDRESS_WIDTH-1:0] S_AXI_ARADDR,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]    S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   input  logic [ADDRESS_WIDTH-1:0] S_AXI_AWADDR,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]    S_AXI_WDATA,
   input  logic [STRB_W-1:0]        S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   output logic [IDX_W-1:0]         mem_addr,
   output logic                     mem_wen,
   output logic [STRB_W-1:0]        mem_wstrb,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata
);

   state_e                state_q, state_d;
   logic                  req_rd, req_wr, gnt_rd, gnt_wr;
   logic [IDX_W-1:0]      ar_idx, aw_idx, mem_addr_q;
   logic                  ar_in_range, aw_in_range;
   logic [1:0]            rresp_q, bresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  unused_addr_lsb;

   assign ar_idx      = S_AXI_ARADDR[IDX_W+1:2];
   assign aw_idx      = S_AXI_AWADDR[IDX_W+1:2];
   assign ar_in_range = (S_AXI_ARADDR[ADDRESS_WIDTH-1:IDX_W+2] == '0);
   assign aw_in_range = (S_AXI_AWADDR[ADDRESS_WIDTH-1:IDX_W+2] == '0);
   assign unused_addr_lsb = ^{S_AXI_ARADDR[1:0], S_AXI_AWADDR[1:0]};

   // Requests only count in IDLE, so a grant is always the handshake cycle itself.
   assign req_rd = (state_q == StIdle) && S_AXI_ARVALID;
   assign req_wr = (state_q == StIdle) && S_AXI_AWVALID && S_AXI_WVALID;

   axi4_lite_rr_arb u_arb (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .req_rd_i (req_rd),
      .req_wr_i (req_wr),
      .gnt_rd_o (gnt_rd),
      .gnt_wr_o (gnt_wr)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      S_AXI_ARREADY = gnt_rd;
      S_AXI_AWREADY = gnt_wr;
      S_AXI_WREADY  = gnt_wr;
      mem_addr      = mem_addr_q;
      mem_wen       = 1'b0;
      mem_wstrb     = '0;
      mem_wdata     = '0;
      unique case (state_q)
         StIdle: begin
            if (gnt_rd) begin
               state_d  = StRdMem;
               mem_addr = ar_idx;
            end else if (gnt_wr) begin
               state_d   = StWrResp;
               mem_addr  = aw_idx;
               mem_wen   = aw_in_range;
               mem_wstrb = S_AXI_WSTRB;
               mem_wdata = S_AXI_WDATA;
            end
         end
         StRdMem: state_d = StRdResp;
         StRdResp: begin
            if (S_AXI_RREADY) state_d = StIdle;
         end
         StWrResp: begin
            if (S_AXI_BREADY) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         mem_addr_q <= '0;
         rresp_q    <= RESP_OKAY;
         bresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         if (gnt_rd) begin
            mem_addr_q <= ar_idx;
            rresp_q    <= resp_of(ar_in_range);
         end
         if (gnt_wr) begin
            mem_addr_q <= aw_idx;
            bresp_q    <= resp_of(aw_in_range);
         end
         // Memory data is valid in RD_MEM; out-of-range reads return zero.
         if (state_q == StRdMem) begin
            rdata_q <= (rresp_q == RESP_OKAY) ? mem_rdata : '0;
         end
      end
   end

   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RRESP  = rresp_q;
   assign S_AXI_RVALID = (state_q == StRdResp);
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_BVALID = (state_q == StWrResp);

endmodule

// File: tb/tb_axi4_lite_mem_sched.sv
// Self-checking bench for axi4_lite_mem_sched: synchronous memory model, reference word array
// and response scoreboards filled at handshake time and drained when responses appear.
module tb_axi4_lite_mem_sched;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [31:0] S_AXI_ARADDR = '0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b0;
   logic [31:0] S_AXI_AWADDR = '0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b0;
   logic [4:0]  mem_addr;
   logic        mem_wen;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] mem     [32];
   logic [31:0] ref_mem [32];
   logic [31:0] exp_rdata_q[$];
   logic [1:0]  exp_rresp_q[$];
   logic [1:0]  exp_bresp_q[$];

   always #5 ACLK = ~ACLK;

   axi4_lite_mem_sched dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_wstrb     (mem_wstrb),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Synchronous 1-cycle-read memory
   always @(posedge ACLK) begin
      if (mem_wen) mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_wstrb);
      mem_rdata <= mem[mem_addr];
   end

   task automatic apply_reset();
      ARESETN = 1'b0;
      S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESETN = 1'b1;
   endtask

   task automatic wr_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         output logic hs, output logic wen, output logic [4:0] maddr,
                         output logic bvalid, output logic [1:0] bresp);
      hs = 1'b0; wen = 1'b0; maddr = '0; bvalid = 1'b0; bresp = 2'b00;
      @(posedge ACLK); #1;
      S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
      for (int i = 0; i < 20 && !hs; i++) begin
         #1;
         if (S_AXI_AWREADY && S_AXI_WREADY) begin
            hs = 1'b1; wen = mem_wen; maddr = mem_addr;
            exp_bresp_q.push_back((addr[31:7] == 0) ? 2'b00 : 2'b10);
            if (addr[31:7] == 0) ref_mem[addr[6:2]] = merge(ref_mem[addr[6:2]], data, strb);
         end
         @(posedge ACLK); #1;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      if (hs) begin
         #1 bvalid = S_AXI_BVALID; bresp = S_AXI_BRESP;
         S_AXI_BREADY = 1'b1;
         @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
      end
   endtask

   task automatic rd_txn(input logic [31:0] addr, input int hold, output logic hs,
                         output logic [4:0] maddr, output logic rv1, output logic rv2,
                         output logic [31:0] rdata, output logic [1:0] rresp, output logic stable);
      hs = 1'b0; maddr = '0; rv1 = 1'b0; rv2 = 1'b0; rdata = '0; rresp = 2'b00; stable = 1'b0;
      @(posedge ACLK); #1;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
      for (int i = 0; i < 20 && !hs; i++) begin
         #1;
         if (S_AXI_ARREADY) begin
            hs = 1'b1; maddr = mem_addr;
            exp_rdata_q.push_back((addr[31:7] == 0) ? ref_mem[addr[6:2]] : 32'h0);
            exp_rresp_q.push_back((addr[31:7] == 0) ? 2'b00 : 2'b10);
         end
         @(posedge ACLK); #1;
      end
      S_AXI_ARVALID = 1'b0;
      if (hs) begin
         #1 rv1 = S_AXI_RVALID;
         @(posedge ACLK); #2;
         rv2 = S_AXI_RVALID; rdata = S_AXI_RDATA; rresp = S_AXI_RRESP; stable = 1'b1;
         repeat (hold) begin
            @(posedge ACLK); #2;
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== rdata || S_AXI_RRESP !== rresp)
               stable = 1'b0;
         end
         S_AXI_RREADY = 1'b1;
         @(posedge ACLK); #1 S_AXI_RREADY = 1'b0;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_cmp++; if (S_AXI_ARREADY !== 1'b0) begin n_err++; $display("FAIL reset_arready: got %b want 0", S_AXI_ARREADY); end
      n_cmp++; if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin n_err++; $display("FAIL reset_awready_wready: got %b%b want 00", S_AXI_AWREADY, S_AXI_WREADY); end
      n_cmp++; if (S_AXI_RVALID !== 1'b0 || S_AXI_BVALID !== 1'b0) begin n_err++; $display("FAIL reset_valids: got %b%b want 00", S_AXI_RVALID, S_AXI_BVALID); end
      n_cmp++; if (S_AXI_RDATA !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", S_AXI_RDATA); end
      n_cmp++; if (S_AXI_RRESP !== 2'b00 || S_AXI_BRESP !== 2'b00) begin n_err++; $display("FAIL reset_resps: got %b/%b want 00/00", S_AXI_RRESP, S_AXI_BRESP); end
      n_cmp++; if (mem_wen !== 1'b0 || mem_addr !== 5'd0) begin n_err++; $display("FAIL reset_mem_port: got wen=%b addr=%0d want 0/0", mem_wen, mem_addr); end
   endtask

   task automatic test_eligibility();
      logic leak = 1'b0;
      @(posedge ACLK); #1;
      S_AXI_AWADDR = 32'h4; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0;
      repeat (3) begin #1 if (S_AXI_AWREADY || S_AXI_WREADY || mem_wen) leak = 1'b1; @(posedge ACLK); #1; end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b1;
      repeat (3) begin #1 if (S_AXI_AWREADY || S_AXI_WREADY || mem_wen) leak = 1'b1; @(posedge ACLK); #1; end
      S_AXI_WVALID = 1'b0;
      n_cmp++; if (leak !== 1'b0) begin n_err++; $display("FAIL partial_write_not_eligible: got ready=%b want 0", leak); end
   endtask

   task automatic test_write();
      logic hs, wen, bv; logic [4:0] ma; logic [1:0] br, eb;
      logic rhs, rv1, rv2, st; logic [4:0] rma; logic [31:0] rd, ed; logic [1:0] rr, er;
      wr_txn(32'h08, 32'hDEADBEEF, 4'hF, hs, wen, ma, bv, br);
      eb = exp_bresp_q.size() ? exp_bresp_q.pop_front() : 2'bxx;
      n_cmp++; if (hs !== 1'b1) begin n_err++; $display("FAIL wr_handshake: got %b want 1", hs); end
      n_cmp++; if (wen !== 1'b1 || ma !== 5'd2) begin n_err++; $display("FAIL wr_mem_pulse: got wen=%b addr=%0d want 1/2", wen, ma); end
      n_cmp++; if (bv !== 1'b1) begin n_err++; $display("FAIL wr_bvalid_n1: got %b want 1", bv); end
      n_cmp++; if (br !== eb) begin n_err++; $display("FAIL wr_bresp: got %b want %b", br, eb); end
      // Partial strobes over a word the bench has never written
      wr_txn(32'h0C, 32'h12345678, 4'b0101, hs, wen, ma, bv, br);
      eb = exp_bresp_q.size() ? exp_bresp_q.pop_front() : 2'bxx;
      n_cmp++; if (br !== eb || ma !== 5'd3) begin n_err++; $display("FAIL wr_strb_resp: got %b/%0d want %b/3", br, ma, eb); end
      rd_txn(32'h0C, 0, rhs, rma, rv1, rv2, rd, rr, st);
      ed = exp_rdata_q.size() ? exp_rdata_q.pop_front() : 32'hx;
      er = exp_rresp_q.size() ? exp_rresp_q.pop_front() : 2'bxx;
      n_cmp++; if (rd !== ed || rr !== er) begin n_err++; $display("FAIL wr_strb_readback: got %h/%b want %h/%b", rd, rr, ed, er); end
   endtask

   task automatic test_read();
      logic hs, rv1, rv2, st; logic [4:0] ma; logic [31:0] rd, ed; logic [1:0] rr, er;
      rd_txn(32'h08, 0, hs, ma, rv1, rv2, rd, rr, st);
      ed = exp_rdata_q.size() ? exp_rdata_q.pop_front() : 32'hx;
      er = exp_rresp_q.size() ? exp_rresp_q.pop_front() : 2'bxx;
      n_cmp++; if (hs !== 1'b1 || ma !== 5'd2) begin n_err++; $display("FAIL rd_handshake: got hs=%b addr=%0d want 1/2", hs, ma); end
      n_cmp++; if (rv1 !== 1'b0 || rv2 !== 1'b1) begin n_err++; $display("FAIL rd_latency: got rvalid n+1=%b n+2=%b want 0/1", rv1, rv2); end
      n_cmp++; if (rd !== ed) begin n_err++; $display("FAIL rd_data: got %h want %h", rd, ed); end
      n_cmp++; if (rr !== er) begin n_err++; $display("FAIL rd_resp: got %b want %b", rr, er); end
   endtask

   task automatic test_out_of_range();
      logic hs, wen, bv; logic [4:0] ma; logic [1:0] br, eb;
      logic rv1, rv2, st; logic [31:0] rd, ed; logic [1:0] rr, er;
      wr_txn(32'h00, 32'hA5A5A5A5, 4'hF, hs, wen, ma, bv, br);
      eb = exp_bresp_q.size() ? exp_bresp_q.pop_front() : 2'bxx;
      n_cmp++; if (br !== eb) begin n_err++; $display("FAIL oor_setup_bresp: got %b want %b", br, eb); end
      wr_txn(32'h80, 32'hFFFFFFFF, 4'hF, hs, wen, ma, bv, br);
      eb = exp_bresp_q.size() ? exp_bresp_q.pop_front() : 2'bxx;
      n_cmp++; if (wen !== 1'b0) begin n_err++; $display("FAIL oor_wr_no_wen: got %b want 0", wen); end
      n_cmp++; if (bv !== 1'b1 || br !== eb) begin n_err++; $display("FAIL oor_wr_bresp: got %b/%b want 1/%b", bv, br, eb); end
      rd_txn(32'h80, 0, hs, ma, rv1, rv2, rd, rr, st);
      ed = exp_rdata_q.size() ? exp_rdata_q.pop_front() : 32'hx;
      er = exp_rresp_q.size() ? exp_rresp_q.pop_front() : 2'bxx;
      n_cmp++; if (rd !== ed || rr !== er) begin n_err++; $display("FAIL oor_rd: got %h/%b want %h/%b", rd, rr, ed, er); end
      rd_txn(32'h00, 0, hs, ma, rv1, rv2, rd, rr, st);
      ed = exp_rdata_q.size() ? exp_rdata_q.pop_front() : 32'hx;
      er = exp_rresp_q.size() ? exp_rresp_q.pop_front() : 2'bxx;
      n_cmp++; if (rd !== ed || rr !== er) begin n_err++; $display("FAIL oor_word0_intact: got %h/%b want %h/%b", rd, rr, ed, er); end
   endtask

   task automatic test_backpressure();
      logic hs = 1'b0, rv, st, aw_after, bv; logic [31:0] rd0, ed; logic [1:0] rr0, er, eb, br;
      int leak = 0;
      @(posedge ACLK); #1;
      S_AXI_ARADDR = 32'h08; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b1;
      for (int i = 0; i < 20 && !hs; i++) begin
         #1;
         if (S_AXI_ARREADY) begin
            hs = 1'b1;
            exp_rdata_q.push_back(ref_mem[2]); exp_rresp_q.push_back(2'b00);
         end
         @(posedge ACLK); #1;
      end
      S_AXI_ARVALID = 1'b0;
      S_AXI_AWADDR = 32'h18; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      #1 if (S_AXI_AWREADY) leak++;
      @(posedge ACLK); #2;
      rv = S_AXI_RVALID; rd0 = S_AXI_RDATA; rr0 = S_AXI_RRESP; st = 1'b1;
      if (S_AXI_AWREADY) leak++;
      repeat (5) begin
         @(posedge ACLK); #2;
         if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== rd0 || S_AXI_RRESP !== rr0) st = 1'b0;
         if (S_AXI_AWREADY) leak++;
      end
      S_AXI_RREADY = 1'b1;
      @(posedge ACLK); #1 S_AXI_RREADY = 1'b0;
      #1 aw_after = S_AXI_AWREADY;
      if (aw_after) begin
         exp_bresp_q.push_back(2'b00);
         ref_mem[6] = 32'hCAFEF00D;
      end
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      #1 bv = S_AXI_BVALID; br = S_AXI_BRESP;
      @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
      ed = exp_rdata_q.size() ? exp_rdata_q.pop_front() : 32'hx;
      er = exp_rresp_q.size() ? exp_rresp_q.pop_front() : 2'bxx;
      eb = exp_bresp_q.size() ? exp_bresp_q.pop_front() : 2'bxx;
      n_cmp++; if (rv !== 1'b1 || rd0 !== ed || rr0 !== er) begin n_err++; $display("FAIL bp_rdata: got %b/%h/%b want 1/%h/%b", rv, rd0, rr0, ed, er); end
      n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %b want 1", st); end
      n_cmp++; if (leak !== 0) begin n_err++; $display("FAIL bp_awready_during_read: got %0d cycles want 0", leak); end
      n_cmp++; if (aw_after !== 1'b1) begin n_err++; $display("FAIL bp_awready_after: got %b want 1", aw_after); end
      n_cmp++; if (bv !== 1'b1 || br !== eb) begin n_err++; $display("FAIL bp_write_resp: got %b/%b want 1/%b", bv, br, eb); end
   endtask

   task automatic test_back_to_back();
      int t[2]; int n = 0; logic stop = 1'b0; logic [1:0] eb;
      t[0] = 0; t[1] = 0;
      @(posedge ACLK); #1;
      S_AXI_AWADDR = 32'h20; S_AXI_WDATA = 32'h5A5A0001; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (stop) begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
         #1;
         if (S_AXI_AWREADY && S_AXI_WREADY && n < 2) begin
            t[n] = c; n++;
            exp_bresp_q.push_back(2'b00); ref_mem[8] = 32'h5A5A0001;
         end
         if (S_AXI_BVALID) begin
            eb = exp_bresp_q.size() ? exp_bresp_q.pop_front() : 2'bxx;
            n_cmp++; if (S_AXI_BRESP !== eb) begin n_err++; $display("FAIL b2b_bresp: got %b want %b", S_AXI_BRESP, eb); end
         end
         if (n == 2) stop = 1'b1;
         if (stop && !S_AXI_BVALID && exp_bresp_q.size() == 0) break;
         @(posedge ACLK); #1;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
      n_cmp++; if (n !== 2 || t[1] - t[0] !== 2) begin n_err++; $display("FAIL b2b_gap: got %0d grants gap %0d want 2/2", n, t[1] - t[0]); end
   endtask

   task automatic test_arbitration();
      logic got_w[4]; logic exp_w[4]; int ng = 0; int conflict = 0; logic stop = 1'b0;
      logic [31:0] ed; logic [1:0] er;
      for (int i = 0; i < 4; i++) got_w[i] = 1'bx;
`ifdef AXI_LITE_RD_PRIO_EN
      exp_w[0] = 1'b0; exp_w[1] = 1'b0; exp_w[2] = 1'b0; exp_w[3] = 1'b0;
`else
      exp_w[0] = 1'b0; exp_w[1] = 1'b1; exp_w[2] = 1'b0; exp_w[3] = 1'b1;
`endif
      apply_reset();
      S_AXI_ARADDR = 32'h10; S_AXI_AWADDR = 32'h10; S_AXI_WDATA = 32'h11112222;
      S_AXI_WSTRB = 4'hF; S_AXI_ARVALID = 1'b1; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (stop) begin S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
         #1;
         if (S_AXI_ARREADY && S_AXI_AWREADY) conflict++;
         if (S_AXI_ARREADY && ng < 4) begin
            got_w[ng] = 1'b0; ng++;
            exp_rdata_q.push_back(ref_mem[4]); exp_rresp_q.push_back(2'b00);
         end else if (S_AXI_AWREADY && S_AXI_WREADY && ng < 4) begin
            got_w[ng] = 1'b1; ng++;
            ref_mem[4] = 32'h11112222; exp_bresp_q.push_back(2'b00);
         end
         if (S_AXI_RVALID) begin
            ed = exp_rdata_q.size() ? exp_rdata_q.pop_front() : 32'hx;
            er = exp_rresp_q.size() ? exp_rresp_q.pop_front() : 2'bxx;
            n_cmp++; if (S_AXI_RDATA !== ed || S_AXI_RRESP !== er) begin n_err++; $display("FAIL arb_rdata: got %h/%b want %h/%b", S_AXI_RDATA, S_AXI_RRESP, ed, er); end
         end
         if (S_AXI_BVALID) begin
            er = exp_bresp_q.size() ? exp_bresp_q.pop_front() : 2'bxx;
            n_cmp++; if (S_AXI_BRESP !== er) begin n_err++; $display("FAIL arb_bresp: got %b want %b", S_AXI_BRESP, er); end
         end
         if (ng == 4) stop = 1'b1;
         if (stop && !S_AXI_RVALID && !S_AXI_BVALID && exp_rdata_q.size() == 0
             && exp_bresp_q.size() == 0) break;
         @(posedge ACLK); #1;
      end
      S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
      n_cmp++; if (ng !== 4 || conflict !== 0) begin n_err++; $display("FAIL arb_grants: got %0d grants %0d dual-ready want 4/0", ng, conflict); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (got_w[i] !== exp_w[i]) begin n_err++; $display("FAIL arb_order[%0d]: got %s want %s", i, got_w[i] ? "W" : "R", exp_w[i] ? "W" : "R"); end
      end
   endtask

   task automatic test_reset_mid();
      logic hs = 1'b0, rv_pre, rv_post, bv_pre, bv_post, rv1, rv2, st; logic [4:0] ma, ma_post;
      logic [31:0] rd, ed, rdata_post; logic [1:0] rr, er;
      @(posedge ACLK); #1;
      S_AXI_ARADDR = 32'h08; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
      for (int i = 0; i < 20 && !hs; i++) begin #1 if (S_AXI_ARREADY) hs = 1'b1; @(posedge ACLK); #1; end
      S_AXI_ARVALID = 1'b0;
      @(posedge ACLK); #1;
      #1 rv_pre = S_AXI_RVALID; ARESETN = 1'b0;
      #1 rv_post = S_AXI_RVALID; ma_post = mem_addr; rdata_post = S_AXI_RDATA;
      @(posedge ACLK); #1 ARESETN = 1'b1;
      n_cmp++; if (hs !== 1'b1 || rv_pre !== 1'b1) begin n_err++; $display("FAIL rst_mid_setup: got hs=%b rvalid=%b want 1/1", hs, rv_pre); end
      n_cmp++; if (rv_post !== 1'b0) begin n_err++; $display("FAIL rst_mid_rvalid: got %b want 0", rv_post); end
      n_cmp++; if (ma_post !== 5'd0 || rdata_post !== 32'h0) begin n_err++; $display("FAIL rst_mid_regs: got addr=%0d rdata=%h want 0/0", ma_post, rdata_post); end
      // Write pulsed, then reset during WR_RESP: data stays committed
      hs = 1'b0;
      @(posedge ACLK); #1;
      S_AXI_AWADDR = 32'h1C; S_AXI_WDATA = 32'h0BADF00D; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
      for (int i = 0; i < 20 && !hs; i++) begin
         #1 if (S_AXI_AWREADY) begin hs = 1'b1; ref_mem[7] = 32'h0BADF00D; end
         @(posedge ACLK); #1;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      #1 bv_pre = S_AXI_BVALID; ARESETN = 1'b0;
      #1 bv_post = S_AXI_BVALID;
      @(posedge ACLK); #1 ARESETN = 1'b1;
      n_cmp++; if (bv_pre !== 1'b1 || bv_post !== 1'b0) begin n_err++; $display("FAIL rst_mid_bvalid: got %b->%b want 1->0", bv_pre, bv_post); end
      rd_txn(32'h1C, 0, hs, ma, rv1, rv2, rd, rr, st);
      ed = exp_rdata_q.size() ? exp_rdata_q.pop_front() : 32'hx;
      er = exp_rresp_q.size() ? exp_rresp_q.pop_front() : 2'bxx;
      n_cmp++; if (rd !== ed || rr !== er) begin n_err++; $display("FAIL rst_mid_write_kept: got %h/%b want %h/%b", rd, rr, ed, er); end
      rd_txn(32'h08, 0, hs, ma, rv1, rv2, rd, rr, st);
      ed = exp_rdata_q.size() ? exp_rdata_q.pop_front() : 32'hx;
      er = exp_rresp_q.size() ? exp_rresp_q.pop_front() : 2'bxx;
      n_cmp++; if (rv2 !== 1'b1 || rd !== ed || rr !== er) begin n_err++; $display("FAIL rst_mid_next_read: got %b/%h/%b want 1/%h/%b", rv2, rd, rr, ed, er); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      test_reset();
      test_eligibility();
      test_write();
      test_read();
      test_out_of_range();
      test_backpressure();
      test_back_to_back();
      test_arbitration();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
